// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int POP_W    = 64;

    // An index names a real, writable register: in range and not the hard-wired zero.
    function automatic logic addr_legal(input int addr, input int nreg, input int zero_reg);
        return !((addr >= nreg) || ((zero_reg != 0) && (addr == 0)));
    endfunction

    function automatic logic [7:0] popcount(input logic [POP_W-1:0] v);
        logic [7:0] cnt;
        cnt = 8'd0;
        for (int i = 0; i < POP_W; i++) begin
            cnt = cnt + {7'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue sets, writeback clears, RAW/WAW hazard flags and a
// registered count of outstanding producers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = 2,
    parameter int AW       = $clog2(NREG),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [AW-1:0]     waddr,
    input  logic [NRD*AW-1:0] raddr,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_rd,
    output logic [NRD-1:0]    raw_haz,
    output logic              waw_haz,
    output logic [AW:0]       pending
);

    logic [NREG-1:0]      busy_q;
    logic [NREG-1:0]      busy_d;
    logic [AW:0]          pending_q;
    logic [AW:0]          pending_d;
    logic [(1<<AW)-1:0]   busy_full_s;
    logic [POP_W-1:0]     busy_ext_s;
    logic [7:0]           pop_s;
    logic                 wr_legal_s;
    logic                 set_s;
    logic                 waw_haz_s;
    logic [NRD-1:0]       raw_haz_s;

    assign wr_legal_s = wen && addr_legal(32'(waddr), NREG, ZERO_REG);

    // Hazard detection; busy_full_s pads unimplemented indices with 0 so they never flag.
    always_comb begin
        logic [AW-1:0] ra_v;
        busy_full_s             = '0;
        busy_full_s[NREG-1:0]   = busy_q;
        raw_haz_s               = '0;
        ra_v                    = '0;
        waw_haz_s = iss_valid && busy_full_s[iss_rd]
                    && !((BYPASS != 0) && wr_legal_s && (waddr == iss_rd));
        set_s     = iss_valid && addr_legal(32'(iss_rd), NREG, ZERO_REG) && !waw_haz_s;
        for (int k = 0; k < NRD; k++) begin
            ra_v = raddr[k*AW +: AW];
            raw_haz_s[k] = addr_legal(32'(ra_v), NREG, ZERO_REG) && busy_full_s[ra_v]
                           && !((BYPASS != 0) && wr_legal_s && (waddr == ra_v));
        end
    end

    // Next busy vector: clear first, then set, so a new producer overrides a retiring one.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREG; i++) begin
            if (wr_legal_s && (waddr == AW'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_d[i];
            end
            if (set_s && (iss_rd == AW'(i))) begin
                busy_d[i] = 1'b1;
            end else begin
                busy_d[i] = busy_d[i];
            end
        end
        busy_ext_s             = '0;
        busy_ext_s[NREG-1:0]   = busy_d;
        pop_s                  = popcount(busy_ext_s);
        pending_d              = pop_s[AW:0];
    end

    // Scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign raw_haz = raw_haz_s;
    assign waw_haz = waw_haz_s;
    assign pending = pending_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port GPR file with writeback bypass, busy-bit scoreboard and a
// registered debug read port used for register dumps.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wen,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      raw_haz,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                waw_haz,
    output logic [AW:0]         pending,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);

    logic [XLEN-1:0]     gpr_q [NREG];
    logic [XLEN-1:0]     dbg_q;
    logic [XLEN-1:0]     dbg_d;
    logic [NRD*XLEN-1:0] rdata_s;
    logic                wr_legal_s;

    assign wr_legal_s = wen && addr_legal(32'(waddr), NREG, ZERO_REG);

    // Unimplemented indices read as 0.
    function automatic logic [XLEN-1:0] gpr_read(input logic [AW-1:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        for (int r = 0; r < NREG; r++) begin
            if (a == AW'(r)) begin
                v = gpr_q[r];
            end else begin
                v = v;
            end
        end
        return v;
    endfunction

    for (genvar r = 0; r < NREG; r++) begin : g_reg
        // One flop row per register; the zero register never sees a legal write.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                gpr_q[r] <= '0;
            end else if (wr_legal_s && (waddr == AW'(r))) begin
                gpr_q[r] <= wdata;
            end else begin
                gpr_q[r] <= gpr_q[r];
            end
        end
    end

    // Read ports: zero for illegal indices, then forwarded writeback data, then storage.
    always_comb begin
        logic [AW-1:0] ra_v;
        rdata_s = '0;
        ra_v    = '0;
        for (int k = 0; k < NRD; k++) begin
            ra_v = raddr[k*AW +: AW];
            if (!addr_legal(32'(ra_v), NREG, ZERO_REG)) begin
                rdata_s[k*XLEN +: XLEN] = '0;
            end else if ((BYPASS != 0) && wr_legal_s && (waddr == ra_v)) begin
                rdata_s[k*XLEN +: XLEN] = wdata;
            end else begin
                rdata_s[k*XLEN +: XLEN] = gpr_read(ra_v);
            end
        end
    end

    assign dbg_d = gpr_read(dbg_addr);

    // Debug port samples storage only, so a same-cycle write shows up one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= dbg_d;
        end
    end

    regfile_scoreboard #(
        .NREG     (NREG),
        .NRD      (NRD),
        .AW       (AW),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .waddr     (waddr),
        .raddr     (raddr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .raw_haz   (raw_haz),
        .waw_haz   (waw_haz),
        .pending   (pending)
    );

    assign rdata    = rdata_s;
    assign dbg_data = dbg_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build, a no-bypass build, and an
// RV32E-sized build with 5-bit indices so out-of-range addresses are reachable.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wen = 1'b0;
    logic [4:0]  waddr = 5'd0;
    logic [31:0] wdata = 32'd0;
    logic [9:0]  raddr = 10'd0;
    logic [14:0] raddr_e = 15'd0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = 5'd0;
    logic [4:0]  dbg_addr = 5'd0;

    logic [63:0] rdata, rdata_nb;
    logic [95:0] rdata_e;
    logic [1:0]  raw, raw_nb;
    logic [2:0]  raw_e;
    logic        waw, waw_nb, waw_e;
    logic [5:0]  pend, pend_nb, pend_e;
    logic [31:0] dbg, dbg_nb, dbg_e;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .raw_haz(raw), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .waw_haz(waw), .pending(pend), .dbg_addr(dbg_addr),
        .dbg_data(dbg)
    );

    regfile_mp #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_nb), .raw_haz(raw_nb), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .waw_haz(waw_nb), .pending(pend_nb), .dbg_addr(dbg_addr),
        .dbg_data(dbg_nb)
    );

    regfile_mp #(.NREG(16), .NRD(3), .AW(5)) u_e (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr_e), .rdata(rdata_e), .raw_haz(raw_e), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .waw_haz(waw_e), .pending(pend_e), .dbg_addr(dbg_addr),
        .dbg_data(dbg_e)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        raddr    = {5'd7, 5'd5};
        dbg_addr = 5'd5;
        #3;
        check("rst_rdata", rdata, 64'd0);
        check("rst_pend", {58'd0, pend}, 64'd0);
        check("rst_raw", {62'd0, raw}, 64'd0);
        check("rst_dbg", {32'd0, dbg}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: write x5, read next cycle; debug port lags by one more cycle
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        wen = 1'b0;
        #1;
        check("t1_rd0", {32'd0, rdata[31:0]}, 64'hDEADBEEF);
        check("t1_dbg_lag", {32'd0, dbg}, 64'd0);
        tick();
        check("t1_dbg", {32'd0, dbg}, 64'hDEADBEEF);

        // 2: writes and issues to x0 are ignored
        raddr = {5'd5, 5'd0};
        wen = 1'b1; waddr = 5'd0; wdata = 32'h1234;
        iss_valid = 1'b1; iss_rd = 5'd0;
        #1;
        check("t2_x0_byp", {32'd0, rdata[31:0]}, 64'd0);
        check("t2_waw0", {63'd0, waw}, 64'd0);
        tick();
        wen = 1'b0; iss_valid = 1'b0;
        #1;
        check("t2_x0", {32'd0, rdata[31:0]}, 64'd0);
        check("t2_port1", {32'd0, rdata[63:32]}, 64'hDEADBEEF);
        check("t2_pend", {58'd0, pend}, 64'd0);

        // 3: same-cycle forward vs. no-bypass build
        raddr = {5'd5, 5'd7};
        wen = 1'b1; waddr = 5'd7; wdata = 32'hA5A5;
        #1;
        check("t3_byp", {32'd0, rdata[31:0]}, 64'hA5A5);
        check("t3_nobyp", {32'd0, rdata_nb[31:0]}, 64'd0);
        tick();
        wen = 1'b0;
        #1;
        check("t3_nobyp_after", {32'd0, rdata_nb[31:0]}, 64'hA5A5);

        // 4: issue x3, re-issue (WAW), writeback clears with bypassed RAW
        raddr = {5'd5, 5'd3};
        iss_valid = 1'b1; iss_rd = 5'd3;
        #1;
        check("t4_waw_first", {63'd0, waw}, 64'd0);
        tick();
        iss_valid = 1'b0;
        #1;
        check("t4_raw", {62'd0, raw}, 64'd1);
        check("t4_pend1", {58'd0, pend}, 64'd1);
        iss_valid = 1'b1; iss_rd = 5'd3;
        #1;
        check("t4_waw", {63'd0, waw}, 64'd1);
        tick();
        iss_valid = 1'b0;
        #1;
        check("t4_pend_still1", {58'd0, pend}, 64'd1);
        wen = 1'b1; waddr = 5'd3; wdata = 32'h33;
        #1;
        check("t4_raw_byp", {62'd0, raw}, 64'd0);
        check("t4_raw_nobyp", {62'd0, raw_nb}, 64'd1);
        check("t4_rd_byp", {32'd0, rdata[31:0]}, 64'h33);
        tick();
        wen = 1'b0;
        #1;
        check("t4_pend0", {58'd0, pend}, 64'd0);
        check("t4_pend0_nb", {58'd0, pend_nb}, 64'd0);

        // 5: issue and writeback to a busy x9 in the same cycle
        raddr = {5'd5, 5'd9};
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b1; iss_rd = 5'd9;
        wen = 1'b1; waddr = 5'd9; wdata = 32'h99;
        #1;
        check("t5_waw_byp", {63'd0, waw}, 64'd0);
        check("t5_waw_nb", {63'd0, waw_nb}, 64'd1);
        tick();
        iss_valid = 1'b0; wen = 1'b0;
        #1;
        check("t5_pend", {58'd0, pend}, 64'd1);
        check("t5_raw", {62'd0, raw}, 64'd1);
        check("t5_pend_nb", {58'd0, pend_nb}, 64'd0);

        // 6: build up pending=4, then asynchronous reset mid-cycle
        for (int r = 10; r <= 12; r++) begin
            iss_valid = 1'b1; iss_rd = 5'(r);
            tick();
        end
        iss_valid = 1'b0;
        raddr = {5'd10, 5'd5};
        #1;
        check("t6_pend4", {58'd0, pend}, 64'd4);
        check("t6_raw_pre", {62'd0, raw}, 64'd2);
        check("t6_rd_pre", {32'd0, rdata[31:0]}, 64'hDEADBEEF);
        rst = 1'b1;
        #1;
        check("t6_rdata", rdata, 64'd0);
        check("t6_pend", {58'd0, pend}, 64'd0);
        check("t6_raw", {62'd0, raw}, 64'd0);
        check("t6_dbg", {32'd0, dbg}, 64'd0);
        #1;
        rst = 1'b0;
        tick();

        // NREG=16 build: index 20 is out of range for writes, reads and issues
        raddr_e = {5'd0, 5'd4, 5'd20};
        wen = 1'b1; waddr = 5'd20; wdata = 32'hBEEF;
        iss_valid = 1'b1; iss_rd = 5'd20;
        #1;
        check("e_rd20_byp", {32'd0, rdata_e[31:0]}, 64'd0);
        check("e_waw20", {63'd0, waw_e}, 64'd0);
        tick();
        iss_valid = 1'b0;
        wen = 1'b1; waddr = 5'd4; wdata = 32'h44;
        dbg_addr = 5'd20;
        #1;
        check("e_pend", {58'd0, pend_e}, 64'd0);
        check("e_rd20", {32'd0, rdata_e[31:0]}, 64'd0);
        check("e_raw", {61'd0, raw_e}, 64'd0);
        check("e_rd4_byp", {32'd0, rdata_e[63:32]}, 64'h44);
        tick();
        wen = 1'b0;
        #1;
        check("e_rd4", {32'd0, rdata_e[63:32]}, 64'h44);
        check("e_rd0", {32'd0, rdata_e[95:64]}, 64'd0);
        check("e_dbg20", {32'd0, dbg_e}, 64'd0);
        check("dut_dbg20", {32'd0, dbg}, 64'hBEEF);
        check("dut_pend20", {58'd0, pend}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
